// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF receiver.
// Optional parity checking is enabled by defining SPDIF_PARITY_CHECK_EN.
package spdif_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    PRE,
    DATA
  } state_t;

  typedef enum logic [1:0] {
    PRE_B,
    PRE_M,
    PRE_W
  } pre_t;

  typedef enum logic [1:0] {
    CLS_1U,
    CLS_2U,
    CLS_3U,
    CLS_ERR
  } cls_t;

  localparam int AUDIO_LSB  = 4;
  localparam int SLOT_V     = 28;
  localparam int SLOT_P     = 31;
  localparam int HUNT_EDGES = 64;

endpackage

// File: rtl/spdif_interval_classifier.sv
// Line synchroniser, edge-interval counter, unit estimator and
// interval classifier for the biphase-mark decoder.
module spdif_interval_classifier
  import spdif_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic spdif,
  input  logic restart,
  output logic ev,
  output cls_t cls,
  output logic sat,
  output logic unit_done
);

  localparam int HW = $clog2(HUNT_EDGES);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic s1, s2, s3, tog;
  logic hunting, primed;
  logic [HW-1:0] hcnt;
  logic [CNT_W-1:0] cnt, umin, u, nmin;
  logic [CNT_W+1:0] iv, t1, t2, t3;
  cls_t ncls;

  assign tog  = s2 ^ s3;
  assign nmin = (cnt < umin) ? cnt : umin;

  always_comb begin
    iv = {2'b00, cnt};
    t1 = {2'b00, u} + {3'b000, u[CNT_W-1:1]};
    t2 = t1 + {2'b00, u};
    t3 = t2 + {2'b00, u};
    if (iv < t1) ncls = CLS_1U;
    else if (iv < t2) ncls = CLS_2U;
    else if (iv < t3) ncls = CLS_3U;
    else ncls = CLS_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      sat       <= 1'b0;
      ev        <= 1'b0;
      cls       <= CLS_1U;
      unit_done <= 1'b0;
      hunting   <= 1'b1;
      primed    <= 1'b0;
      hcnt      <= '0;
      umin      <= CMAX;
      u         <= '0;
    end else begin
      s1        <= spdif;
      s2        <= s1;
      s3        <= s2;
      ev        <= 1'b0;
      unit_done <= 1'b0;
      sat       <= !tog && (cnt == CMAX - 1'b1);
      if (tog) cnt <= 1;
      else if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (restart) begin
        hunting <= 1'b1;
        hcnt    <= '0;
        umin    <= CMAX;
      end else if (tog) begin
        // the interval ending at the first edge after reset is partial
        if (!primed) begin
          primed <= 1'b1;
        end else if (hunting) begin
          umin <= nmin;
          hcnt <= hcnt + 1'b1;
          if (hcnt == HW'(HUNT_EDGES - 1)) begin
            hunting   <= 1'b0;
            u         <= nmin;
            unit_done <= 1'b1;
          end
        end else begin
          ev  <= 1'b1;
          cls <= ncls;
        end
      end
    end
  end

endmodule

// File: rtl/spdif_rx_core.sv
// S/PDIF subframe decoder and stereo frame assembler.
// Parity checking is built in when SPDIF_PARITY_CHECK_EN is defined.
module spdif_rx_core
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W    = 24,
  parameter int CNT_W       = 8,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spdif_i,
  output logic [SAMPLE_W-1:0] left_o,
  output logic [SAMPLE_W-1:0] right_o,
  output logic                sample_valid_o,
  output logic                block_start_o,
  output logic                locked_o,
  output logic                parity_err_o
);

  localparam int DW = SLOT_P - AUDIO_LSB + 1;
  localparam int AW = SLOT_V - AUDIO_LSB;
  localparam int LW = $clog2(LOCK_FRAMES + 1);

  logic ev, sat, unit_done, restart;
  cls_t cls, p1, p2;
  state_t state;
  pre_t pre, pre_sel;
  logic pre_hit, bit_done, bad_bit, frame_err;
  logic half, pend_v, pend_b;
  logic [1:0] pidx, since;
  logic [4:0] bcnt;
  logic [DW-2:0] sr;
  logic [DW-1:0] word;
  logic [SAMPLE_W-1:0] pend, sample;
  logic [LW-1:0] good;

  spdif_interval_classifier #(
    .CNT_W(CNT_W)
  ) u_cls (
    .clk      (clk),
    .rst      (rst),
    .spdif    (spdif_i),
    .restart  (restart),
    .ev       (ev),
    .cls      (cls),
    .sat      (sat),
    .unit_done(unit_done)
  );

  always_comb begin
    word    = {cls == CLS_1U, sr};
    sample  = word[AW-1 -: SAMPLE_W];
    pre_hit = 1'b1;
    pre_sel = PRE_B;
    if (p1 == CLS_1U && p2 == CLS_1U && cls == CLS_3U) pre_sel = PRE_B;
    else if (p1 == CLS_3U && p2 == CLS_1U && cls == CLS_1U) pre_sel = PRE_M;
    else if (p1 == CLS_2U && p2 == CLS_1U && cls == CLS_2U) pre_sel = PRE_W;
    else pre_hit = 1'b0;
    bit_done = (state == DATA) && ev &&
               ((cls == CLS_1U && half) || (cls == CLS_2U && !half));
    bad_bit  = (state == DATA) && ev &&
               ((cls == CLS_2U && half) || cls == CLS_3U);
    frame_err = (state != HUNT) &&
                (sat || (ev && cls == CLS_ERR) || bad_bit ||
                 ((state == PRE) && ev && pidx == 2'd2 && !pre_hit));
  end

`ifdef SPDIF_PARITY_CHECK_EN
  logic par_ok;
  assign par_ok = ~^word;
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      pre            <= PRE_B;
      p1             <= CLS_1U;
      p2             <= CLS_1U;
      pidx           <= '0;
      since          <= '0;
      bcnt           <= '0;
      half           <= 1'b0;
      sr             <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      pend_b         <= 1'b0;
      good           <= '0;
      restart        <= 1'b0;
      left_o         <= '0;
      right_o        <= '0;
      sample_valid_o <= 1'b0;
      block_start_o  <= 1'b0;
      locked_o       <= 1'b0;
`ifdef SPDIF_PARITY_CHECK_EN
      parity_err_o   <= 1'b0;
`endif
    end else begin
      sample_valid_o <= 1'b0;
      block_start_o  <= 1'b0;
      restart        <= 1'b0;
`ifdef SPDIF_PARITY_CHECK_EN
      parity_err_o   <= 1'b0;
`endif
      if (frame_err) begin
        state    <= HUNT;
        restart  <= 1'b1;
        locked_o <= 1'b0;
        pend_v   <= 1'b0;
        good     <= '0;
      end else begin
        unique case (state)
          HUNT: begin
            if (unit_done) begin
              state <= SYNC;
              since <= '0;
            end
          end
          SYNC: begin
            // a 3u within three intervals of another 3u sits inside a preamble
            if (ev) begin
              if (cls == CLS_3U && since == 2'd3) begin
                state <= PRE;
                pidx  <= '0;
              end else if (cls == CLS_3U) begin
                since <= '0;
              end else if (since != 2'd3) begin
                since <= since + 1'b1;
              end
            end
          end
          PRE: begin
            if (ev) begin
              pidx <= pidx + 1'b1;
              if (pidx == 2'd0) p1 <= cls;
              if (pidx == 2'd1) p2 <= cls;
              if (pidx == 2'd2) begin
                state <= DATA;
                pre   <= pre_sel;
                bcnt  <= '0;
                half  <= 1'b0;
              end
            end
          end
          DATA: begin
            if (ev && cls == CLS_1U && !half) begin
              half <= 1'b1;
            end else if (bit_done) begin
              half <= 1'b0;
              sr   <= word[DW-1:1];
              bcnt <= bcnt + 1'b1;
              if (bcnt == 5'(DW - 1)) begin
                state <= SYNC;
                since <= 2'd3;
`ifdef SPDIF_PARITY_CHECK_EN
                if (!par_ok) begin
                  parity_err_o <= 1'b1;
                  pend_v       <= 1'b0;
                  good         <= '0;
                  locked_o     <= 1'b0;
                end else
`endif
                if (pre == PRE_W) begin
                  pend_v <= 1'b0;
                  if (pend_v) begin
                    left_o         <= pend;
                    right_o        <= sample;
                    sample_valid_o <= 1'b1;
                    block_start_o  <= pend_b;
                    if (good >= LW'(LOCK_FRAMES - 1)) locked_o <= 1'b1;
                    if (good < LW'(LOCK_FRAMES)) good <= good + 1'b1;
                  end
                end else begin
                  pend   <= sample;
                  pend_v <= 1'b1;
                  pend_b <= (pre == PRE_B);
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
